// File: rtl/drum_sequencer.sv
// Purpose: 16-step, 3-voice drum step sequencer; fires per-voice go pulses and a shared divided count-enable.
// Latency: start sampled at edge k -> FIRE (voice_go = pattern[0]) in cycle k+1; step period = max(step_len,2) clocks.
// Backpressure: none; outputs are free-running strobes decoded from registered state, inputs are levels/strobes.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   start, stop, loop                playback control (stop has priority over everything)
//   step_len[13:0]                   step length in clocks (0/1 behave as 2)
//   pat_wr, pat_addr[3:0], pat_data  pattern register-file write port (bit0 hat, bit1 snare, bit2 kick)
//   voice_go[2:0], voice_en          per-voice start pulse, shared count-enable strobe
//   step[3:0], running, done         current step, FIRE/WAIT indicator, end-of-one-shot pulse
module drum_sequencer #(
    parameter int STEPS  = 16,
    parameter int EN_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [13:0] step_len,
    input  logic        pat_wr,
    input  logic [3:0]  pat_addr,
    input  logic [2:0]  pat_data,
    output logic [2:0]  voice_go,
    output logic        voice_en,
    output logic [3:0]  step,
    output logic        running,
    output logic        done
);

    localparam int             PW        = $clog2(EN_DIV);
    localparam logic [3:0]     STEP_LAST = 4'(STEPS - 1);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(EN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     step_q, step_d;
    logic [13:0]    dwell_q, dwell_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic           done_q, done_d;
    logic [2:0]     pattern_q [STEPS];
    logic [2:0]     pattern_d [STEPS];

    logic [13:0]    len_eff;
    logic           step_end;

    // Short step lengths collapse to the minimum of one FIRE plus one WAIT clock.
    // The compare is live against step_len, so shrinking it below the current
    // dwell lets the counter run round modulo 2^14 before the step ends.
    always_comb begin
        len_eff  = (step_len < 14'd2) ? 14'd2 : step_len;
        step_end = (dwell_q == (len_eff - 14'd1));
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        pre_d   = pre_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    step_d  = 4'd0;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    dwell_d = 14'd1;
                    pre_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    dwell_d = dwell_q + 14'd1;
                    pre_d   = (pre_q == PRE_LAST) ? '0 : (pre_q + PW'(1));
                    if (step_end) begin
                        if (step_q != STEP_LAST) begin
                            step_d  = step_q + 4'd1;
                            state_d = FIRE;
                        end else if (loop) begin
                            step_d  = 4'd0;
                            state_d = FIRE;
                        end else begin
                            // One-shot pass complete: step stays on the last index.
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writes land at the clock edge, so a FIRE in the same cycle as a write to
    // its own address still reads the old mask.
    always_comb begin
        pattern_d = pattern_q;
        if (pat_wr && (32'(pat_addr) < STEPS)) begin
            pattern_d[pat_addr] = pat_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            dwell_q <= 14'd0;
            pre_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                pattern_q[i] <= 3'b000;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            dwell_q   <= dwell_d;
            pre_q     <= pre_d;
            done_q    <= done_d;
            pattern_q <= pattern_d;
        end
    end

    // Outputs are pure decodes of flops, so async reset clears them immediately.
    always_comb begin
        voice_go = (state_q == FIRE) ? pattern_q[step_q] : 3'b000;
        voice_en = (state_q == WAIT) && (pre_q == PRE_LAST);
        step     = step_q;
        running  = (state_q != IDLE);
        done     = done_q;
    end

endmodule

// File: tb/tb_drum_sequencer.sv
module tb_drum_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [13:0] step_len = 14'd0;
    logic        pat_wr = 1'b0;
    logic [3:0]  pat_addr = 4'd0;
    logic [2:0]  pat_data = 3'd0;
    logic [2:0]  voice_go;
    logic        voice_en;
    logic [3:0]  step;
    logic        running;
    logic        done;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [2:0] tb_pat [16];

    typedef struct {
        int         c;
        logic [2:0] go;
        logic       en;
        logic [3:0] st;
        logic       dn;
    } ev_t;

    ev_t exp_q[$];

    drum_sequencer #(.STEPS(16), .EN_DIV(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .step_len (step_len),
        .pat_wr   (pat_wr),
        .pat_addr (pat_addr),
        .pat_data (pat_data),
        .voice_go (voice_go),
        .voice_en (voice_en),
        .step     (step),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle with visible activity must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (resetn && (voice_go != 3'b000 || voice_en || done)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: cycle %0d go=%b en=%b step=%0d done=%b, required no event",
                         cyc, voice_go, voice_en, step, done);
            end else begin
                e = exp_q.pop_front();
                if (e.c == cyc && e.go == voice_go && e.en == voice_en && e.st == step && e.dn == done) begin
                    n_pass++;
                end else begin
                    $display("FAIL event: got cycle %0d go=%b en=%b step=%0d done=%b, required cycle %0d go=%b en=%b step=%0d done=%b",
                             cyc, voice_go, voice_en, step, done, e.c, e.go, e.en, e.st, e.dn);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ev(input int c, input logic [2:0] go, input logic en,
                           input logic [3:0] st, input logic dn);
        ev_t e;
        e.c  = c;
        e.go = go;
        e.en = en;
        e.st = st;
        e.dn = dn;
        exp_q.push_back(e);
    endtask

    // Expected events of one step whose FIRE is at cycle f: go pulse (if mask
    // non-zero) then voice_en every 4 clocks inside the step, up to cycle lim.
    task automatic push_step(input int f, input int len, input int idx,
                             input logic [2:0] m, input int lim);
        int leff;
        logic [3:0] st;
        leff = (len < 2) ? 2 : len;
        st = 4'(idx);
        if (m != 3'b000) push_ev(f, m, 1'b0, st, 1'b0);
        for (int t = f + 4; t <= f + leff - 1 && t <= lim; t += 4)
            push_ev(t, 3'b000, 1'b1, st, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic write_pat(input int a, input logic [2:0] d);
        pat_wr   = 1'b1;
        pat_addr = 4'(a);
        pat_data = d;
        tick();
        pat_wr   = 1'b0;
        tb_pat[a] = d;
    endtask

    task automatic run_oneshot(input int len);
        int s;
        int leff;
        leff = (len < 2) ? 2 : len;
        step_len = 14'(len);
        loop = 1'b0;
        s = cyc;
        for (int i = 0; i < 16; i++)
            push_step(s + 1 + leff * i, len, i, tb_pat[i], 1 << 30);
        push_ev(s + 1 + 16 * leff, 3'b000, 1'b0, 4'd15, 1'b1);
        pulse_start();
        check("oneshot_first_fire_running", int'(running), 1);
        wait_cyc(s + 16 * leff + 4);
        check("oneshot_idle_after", int'(running), 0);
        check("oneshot_step_hold", int'(step), 15);
    endtask

    initial begin
        int s;
        int f18;
        for (int i = 0; i < 16; i++) tb_pat[i] = 3'b000;

        // Reset state
        tick();
        tick();
        check("rst_running", int'(running), 0);
        check("rst_voice_go", int'(voice_go), 0);
        check("rst_voice_en", int'(voice_en), 0);
        check("rst_step", int'(step), 0);
        check("rst_done", int'(done), 0);
        resetn = 1'b1;
        tick();

        // Pattern + start, then stop priority during WAIT of step 3
        write_pat(0, 3'b101);
        write_pat(1, 3'b010);
        check("idle_after_writes", int'(running), 0);
        step_len = 14'd5;
        loop = 1'b1;
        s = cyc;
        push_step(s + 1,  5, 0, tb_pat[0], 1 << 30);
        push_step(s + 6,  5, 1, tb_pat[1], 1 << 30);
        push_step(s + 11, 5, 2, tb_pat[2], 1 << 30);
        pulse_start();
        check("fire0_step", int'(step), 0);
        check("fire0_running", int'(running), 1);
        wait_cyc(s + 6);
        check("fire1_step", int'(step), 1);
        wait_cyc(s + 17);
        check("wait3_step", int'(step), 3);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        check("stop_running", int'(running), 0);
        check("stop_step_hold", int'(step), 3);
        check("stop_no_done", int'(done), 0);
        tick();
        tick();
        check("stop_stays_idle", int'(running), 0);

        // One-shot passes (restart from step 0), step_len 2 and 0
        run_oneshot(2);
        tick();
        run_oneshot(0);
        tick();

        // Looping with step_len 9: enable strobes, write to the playing step
        step_len = 14'd9;
        loop = 1'b1;
        s = cyc;
        f18 = s + 1 + 9 * 18;
        for (int g = 0; g <= 18; g++)
            push_step(s + 1 + 9 * g, 9, g % 16,
                      (g == 18) ? 3'b111 : tb_pat[g % 16],
                      (g == 18) ? f18 + 4 : (1 << 30));
        pulse_start();
        wait_cyc(s + 19);
        check("fire2_step", int'(step), 2);
        check("fire2_go_old", int'(voice_go), 0);
        write_pat(2, 3'b111);
        wait_cyc(f18 + 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop_running", int'(running), 0);
        check("loop_stop_step", int'(step), 2);
        tick();

        // Asynchronous reset in the middle of WAIT
        step_len = 14'd9;
        loop = 1'b1;
        s = cyc;
        push_step(s + 1, 9, 0, tb_pat[0], s + 5);
        pulse_start();
        wait_cyc(s + 5);
        check("en_before_rst", int'(voice_en), 1);
        #6;
        resetn = 1'b0;
        #1;
        check("arst_running", int'(running), 0);
        check("arst_voice_go", int'(voice_go), 0);
        check("arst_voice_en", int'(voice_en), 0);
        check("arst_step", int'(step), 0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) tb_pat[i] = 3'b000;
        tick();
        tick();
        check("post_rst_idle", int'(running), 0);
        run_oneshot(2);
        tick();
        tick();

        check("events_all_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
